// File: rtl/boot_loader_pkg.sv
// Shared types and defaults for the rv32i boot loader.
// The optional checksum trailer is selected with BOOT_CHECKSUM_EN.
package boot_loader_pkg;

   localparam int DATA_WIDTH   = 32;
   localparam int I_BRAM_DEPTH = 1024;
   localparam int D_BRAM_DEPTH = I_BRAM_DEPTH;

   typedef enum logic [2:0] {
      BOOT_HDR    = 3'd0,
      BOOT_LOAD_D = 3'd1,
      BOOT_LOAD_I = 3'd2,
      BOOT_CHECK  = 3'd3,
      BOOT_RUN    = 3'd4,
      BOOT_ERR    = 3'd5
   } boot_state_e;

   // States in which the loader consumes stream words.
   function automatic logic boot_accepts(input boot_state_e st);
      return (st == BOOT_HDR) || (st == BOOT_LOAD_D) ||
             (st == BOOT_LOAD_I) || (st == BOOT_CHECK);
   endfunction

endpackage

// File: rtl/boot_xor_acc.sv
// Running XOR of accepted stream words; instantiated by boot_loader only when
// BOOT_CHECKSUM_EN is defined.
module boot_xor_acc #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] acc_o
);

   logic [W-1:0] acc_q;
   logic [W-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (en_i) begin
         acc_d = acc_q ^ din_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/boot_loader.sv
// Boot-time load sequencer: streams the data and program images into the BRAMs,
// then releases the CPU. BOOT_CHECKSUM_EN adds an XOR checksum trailer word.
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int ADDR_WIDTH    = 12,
   parameter int I_DEPTH_WORDS = I_BRAM_DEPTH,
   parameter int D_DEPTH_WORDS = D_BRAM_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic [ADDR_WIDTH-1:0] i_w_addr,
   output logic [DATA_WIDTH-1:0] i_w_dat,
   output logic                  i_w_enb,
   output logic [3:0]            i_w_byte_enb,
   output logic [ADDR_WIDTH-1:0] d_w_addr,
   output logic [DATA_WIDTH-1:0] d_w_dat,
   output logic                  d_w_enb,
   output logic [3:0]            d_w_byte_enb,
   output logic                  d_bram_init_done,
   output logic                  pc_stall,
   output logic                  rd_enbl,
   output logic                  i_r_enb,
   output logic                  boot_done,
   output logic                  boot_error
);

   localparam int CW = ADDR_WIDTH - 2;

`ifdef BOOT_CHECKSUM_EN
   localparam boot_state_e PAYLOAD_END = BOOT_CHECK;
`else
   localparam boot_state_e PAYLOAD_END = BOOT_RUN;
`endif

   boot_state_e           state_q, state_d;
   logic [15:0]           nd_q, nd_d;
   logic [15:0]           ni_q, ni_d;
   logic [CW-1:0]         dcnt_q, dcnt_d;
   logic [CW-1:0]         icnt_q, icnt_d;
   logic                  s_ready_q;
   logic [ADDR_WIDTH-1:0] i_w_addr_q, d_w_addr_q;
   logic [DATA_WIDTH-1:0] i_w_dat_q, d_w_dat_q;
   logic                  i_w_enb_q, d_w_enb_q;
   logic [3:0]            i_w_be_q, d_w_be_q;
   logic                  init_done_q;
   logic                  run_q, run_d;
   logic                  pc_stall_q;
   logic                  err_q;
   logic                  accept;
   logic                  d_wr, i_wr;
   logic                  hdr_bad, last_d, last_i;
   logic [DATA_WIDTH-1:0] acc;

   assign accept  = s_valid & s_ready_q;
   assign hdr_bad = ({16'd0, s_data[31:16]} > D_DEPTH_WORDS) ||
                    ({16'd0, s_data[15:0]}  > I_DEPTH_WORDS);
   assign last_d  = (32'(dcnt_q) + 32'd1) == {16'd0, nd_q};
   assign last_i  = (32'(icnt_q) + 32'd1) == {16'd0, ni_q};

`ifdef BOOT_CHECKSUM_EN
   logic acc_en;
   assign acc_en = accept && (state_q inside {BOOT_HDR, BOOT_LOAD_D, BOOT_LOAD_I});

   boot_xor_acc #(.W(DATA_WIDTH)) u_xor_acc (
      .clk_i (clk),
      .clr_i (rst),
      .en_i  (acc_en),
      .din_i (s_data),
      .acc_o (acc)
   );
`else
   assign acc = '0;
`endif

   always_comb begin
      state_d = state_q;
      nd_d    = nd_q;
      ni_d    = ni_q;
      dcnt_d  = dcnt_q;
      icnt_d  = icnt_q;
      d_wr    = 1'b0;
      i_wr    = 1'b0;
      case (state_q)
         BOOT_HDR: begin
            if (accept) begin
               nd_d   = s_data[31:16];
               ni_d   = s_data[15:0];
               dcnt_d = '0;
               icnt_d = '0;
               if (hdr_bad) begin
                  state_d = BOOT_ERR;
               end else if (s_data[31:16] != 16'd0) begin
                  state_d = BOOT_LOAD_D;
               end else if (s_data[15:0] != 16'd0) begin
                  state_d = BOOT_LOAD_I;
               end else begin
                  state_d = PAYLOAD_END;
               end
            end
         end
         BOOT_LOAD_D: begin
            if (accept) begin
               d_wr   = 1'b1;
               dcnt_d = dcnt_q + CW'(1);
               if (last_d) begin
                  state_d = (ni_q != 16'd0) ? BOOT_LOAD_I : PAYLOAD_END;
               end
            end
         end
         BOOT_LOAD_I: begin
            if (accept) begin
               i_wr   = 1'b1;
               icnt_d = icnt_q + CW'(1);
               if (last_i) begin
                  state_d = PAYLOAD_END;
               end
            end
         end
         BOOT_CHECK: begin
            if (accept) begin
               state_d = (s_data == acc) ? BOOT_RUN : BOOT_ERR;
            end
         end
         default: begin
         end
      endcase
   end

   // With the checksum, release follows the trailer accept directly; otherwise
   // it lands one cycle after the final write strobe.
   always_comb begin
`ifdef BOOT_CHECKSUM_EN
      run_d = (state_d == BOOT_RUN);
`else
      run_d = (state_q == BOOT_RUN);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= BOOT_HDR;
         nd_q        <= '0;
         ni_q        <= '0;
         dcnt_q      <= '0;
         icnt_q      <= '0;
         s_ready_q   <= 1'b0;
         d_w_addr_q  <= '0;
         d_w_dat_q   <= '0;
         d_w_enb_q   <= 1'b0;
         d_w_be_q    <= 4'h0;
         i_w_addr_q  <= '0;
         i_w_dat_q   <= '0;
         i_w_enb_q   <= 1'b0;
         i_w_be_q    <= 4'h0;
         init_done_q <= 1'b0;
         run_q       <= 1'b0;
         pc_stall_q  <= 1'b1;
         err_q       <= 1'b0;
      end else begin
         state_q   <= state_d;
         nd_q      <= nd_d;
         ni_q      <= ni_d;
         dcnt_q    <= dcnt_d;
         icnt_q    <= icnt_d;
         s_ready_q <= boot_accepts(state_d);
         d_w_enb_q <= d_wr;
         d_w_be_q  <= d_wr ? 4'hF : 4'h0;
         i_w_enb_q <= i_wr;
         i_w_be_q  <= i_wr ? 4'hF : 4'h0;
         if (d_wr) begin
            d_w_addr_q <= {dcnt_q, 2'b00};
            d_w_dat_q  <= s_data;
         end
         if (i_wr) begin
            i_w_addr_q <= {icnt_q, 2'b00};
            i_w_dat_q  <= s_data;
         end
         // Once the data image is in, only a checksum failure keeps it flagged in ERR.
         init_done_q <= (state_q inside {BOOT_LOAD_I, BOOT_CHECK, BOOT_RUN}) ||
                        ((state_q == BOOT_ERR) && init_done_q);
         run_q       <= run_d;
         pc_stall_q  <= ~run_d;
         err_q       <= (state_d == BOOT_ERR);
      end
   end

   assign s_ready          = s_ready_q;
   assign i_w_addr         = i_w_addr_q;
   assign i_w_dat          = i_w_dat_q;
   assign i_w_enb          = i_w_enb_q;
   assign i_w_byte_enb     = i_w_be_q;
   assign d_w_addr         = d_w_addr_q;
   assign d_w_dat          = d_w_dat_q;
   assign d_w_enb          = d_w_enb_q;
   assign d_w_byte_enb     = d_w_be_q;
   assign d_bram_init_done = init_done_q;
   assign pc_stall         = pc_stall_q;
   assign rd_enbl          = run_q;
   assign i_r_enb          = run_q;
   assign boot_done        = run_q;
   assign boot_error       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: random payload streams compared against
// a list-of-writes model of the load image; covers BOOT_CHECKSUM_EN when defined.
module tb_boot_loader;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int W  = 2 + AW + DW + 4;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic [AW-1:0] i_w_addr, d_w_addr;
   logic [DW-1:0] i_w_dat, d_w_dat;
   logic          i_w_enb, d_w_enb;
   logic [3:0]    i_w_byte_enb, d_w_byte_enb;
   logic          d_bram_init_done, pc_stall, rd_enbl, i_r_enb, boot_done, boot_error;

   boot_loader #(.ADDR_WIDTH(AW), .I_DEPTH_WORDS(DEPTH), .D_DEPTH_WORDS(DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .s_valid          (s_valid),
      .s_data           (s_data),
      .s_ready          (s_ready),
      .i_w_addr         (i_w_addr),
      .i_w_dat          (i_w_dat),
      .i_w_enb          (i_w_enb),
      .i_w_byte_enb     (i_w_byte_enb),
      .d_w_addr         (d_w_addr),
      .d_w_dat          (d_w_dat),
      .d_w_enb          (d_w_enb),
      .d_w_byte_enb     (d_w_byte_enb),
      .d_bram_init_done (d_bram_init_done),
      .pc_stall         (pc_stall),
      .rd_enbl          (rd_enbl),
      .i_r_enb          (i_r_enb),
      .boot_done        (boot_done),
      .boot_error       (boot_error)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard state
   int            n_checks = 0;
   int            n_pass   = 0;
   logic [W-1:0]  exp_q[$];
   logic [DW-1:0] pay_q[$];
   bit            mon_en   = 1'b0;
   bit            prev_acc = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Write-strobe monitor: every strobe must follow an accept and match the next model write.
   always @(negedge clk) begin
      if (mon_en) begin
         if (d_w_enb || i_w_enb) begin
            check("strobe_after_accept", {63'd0, prev_acc}, 64'd1);
            check("strobe_expected", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
               check("write", {14'd0, d_w_enb, i_w_enb,
                               (i_w_enb ? i_w_addr : d_w_addr),
                               (i_w_enb ? i_w_dat : d_w_dat),
                               (i_w_enb ? i_w_byte_enb : d_w_byte_enb)},
                     {14'd0, exp_q.pop_front()});
            end
         end
         prev_acc = s_valid && s_ready;
      end
   end

   // driver tasks (inputs change 2 time units after the rising edge)
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic hold_valid(input int n);
      s_valid = 1'b1;
      s_data  = $urandom;
      repeat (n) step();
      s_valid = 1'b0;
   endtask

   task automatic send_word(input logic [DW-1:0] w, output bit ok);
      ok      = 1'b0;
      s_valid = 1'b1;
      s_data  = w;
      for (int n = 0; n < 16 && !ok; n++) begin
         @(negedge clk);
         if (s_ready) ok = 1'b1;
         step();
      end
      s_valid = 1'b0;
      s_data  = $urandom;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      s_valid = 1'b0;
      repeat (2) step();
      @(negedge clk);
      check("rst_s_ready",  {63'd0, s_ready}, 64'd0);
      check("rst_enables",  {62'd0, d_w_enb, i_w_enb}, 64'd0);
      check("rst_addr",     {40'd0, d_w_addr, i_w_addr}, 64'd0);
      check("rst_dat",      {d_w_dat, i_w_dat}, 64'd0);
      check("rst_be",       {56'd0, d_w_byte_enb, i_w_byte_enb}, 64'd0);
      check("rst_status",   {58'd0, d_bram_init_done, pc_stall, rd_enbl, i_r_enb,
                                    boot_done, boot_error}, 64'b010000);
      rst = 1'b0;
      step();
      @(negedge clk);
      check("hdr_ready", {63'd0, s_ready}, 64'd1);
      step();
   endtask

   task automatic final_status(input string tag, input bit exp_run, input bit exp_init);
      check({tag, "_boot_done"},  {63'd0, boot_done},  {63'd0, exp_run});
      check({tag, "_rd_enbl"},    {62'd0, rd_enbl, i_r_enb}, {62'd0, exp_run, exp_run});
      check({tag, "_pc_stall"},   {63'd0, pc_stall},   {63'd0, !exp_run});
      check({tag, "_boot_error"}, {63'd0, boot_error}, {63'd0, !exp_run});
      check({tag, "_init_done"},  {63'd0, d_bram_init_done}, {63'd0, exp_init});
      check({tag, "_s_ready"},    {63'd0, s_ready}, 64'd0);
      check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   // Reference: the image is a list of (bram, word index, value) writes in stream order.
   task automatic run_stream(input int nd, input int ni, input int max_gap,
                             input bit corrupt, input string tag);
      logic [DW-1:0] hdr, csum;
      bit            ok, all_ok, hdr_err, is_i;
      int            idx;
      hdr     = {nd[15:0], ni[15:0]};
      hdr_err = (nd > DEPTH) || (ni > DEPTH);
      csum    = hdr;
      if (!hdr_err) begin
         while (pay_q.size() < nd + ni) pay_q.push_back($urandom);
         for (int k = 0; k < nd + ni; k++) begin
            is_i = (k >= nd);
            idx  = is_i ? k - nd : k;
            exp_q.push_back({!is_i, is_i, AW'(idx * 4), pay_q[k], 4'hF});
            csum = csum ^ pay_q[k];
         end
      end
      send_word(hdr, ok);
      check({tag, "_hdr_accept"}, {63'd0, ok}, 64'd1);
      if (hdr_err) begin
         @(negedge clk);
         check({tag, "_err_ready"}, {63'd0, s_ready}, 64'd0);
         step();
         hold_valid(3);
         @(negedge clk);
         final_status(tag, 1'b0, 1'b0);
         step();
      end else begin
         all_ok = 1'b1;
         for (int k = 0; k < nd + ni; k++) begin
            idle($urandom_range(0, max_gap));
            send_word(pay_q[k], ok);
            all_ok &= ok;
         end
`ifdef BOOT_CHECKSUM_EN
         if (corrupt) csum = csum ^ (32'd1 << $urandom_range(0, 31));
         send_word(csum, ok);
         all_ok &= ok;
         check({tag, "_payload_accept"}, {63'd0, all_ok}, 64'd1);
         @(negedge clk);
         check({tag, "_release_edge"}, {63'd0, pc_stall}, {63'd0, corrupt});
         step();
`else
         check({tag, "_payload_accept"}, {63'd0, all_ok}, 64'd1);
         @(negedge clk);
         check({tag, "_stall_held"}, {63'd0, pc_stall}, 64'd1);
         step();
         @(negedge clk);
         check({tag, "_release_edge"}, {63'd0, pc_stall}, 64'd0);
         step();
`endif
         idle(2);
         @(negedge clk);
         final_status(tag, !corrupt, 1'b1);
         step();
      end
      pay_q.delete();
   endtask

   task automatic mid_load_reset();
      bit ok;
      pay_q.delete();
      for (int k = 0; k < 7; k++) pay_q.push_back($urandom);
      for (int k = 0; k < 7; k++)
         exp_q.push_back({k < 4, k >= 4, AW'((k < 4 ? k : k - 4) * 4), pay_q[k], 4'hF});
      send_word(32'h0004_0003, ok);
      send_word(pay_q[0], ok);
      send_word(pay_q[1], ok);
      check("midrst_accept", {63'd0, ok}, 64'd1);
      do_reset();
      check("midrst_pending", 64'(exp_q.size()), 64'd5);
      exp_q.delete();
      pay_q.delete();
   endtask

   // directed sequence
   initial begin
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      do_reset();
      mon_en  = 1'b1;

      pay_q = '{32'h0000_002A, 32'h0000_0002, 32'h0000_000A};
      run_stream(3, 8, 0, 1'b0, "tp_basic");
      hold_valid(3);
      @(negedge clk);
      final_status("run_ignores", 1'b1, 1'b1);
      step();

      do_reset();
      run_stream(0, 2, 0, 1'b0, "no_data");

      do_reset();
      run_stream(1025, 1, 0, 1'b0, "nd_too_big");

      do_reset();
      run_stream(1, 1025, 0, 1'b0, "ni_too_big");

      for (int r = 0; r < 3; r++) begin
         do_reset();
         run_stream($urandom_range(1, 24), $urandom_range(1, 24), 3, 1'b0, "gaps");
      end

      do_reset();
      run_stream(0, 0, 0, 1'b0, "empty");

      do_reset();
      mid_load_reset();
      run_stream(4, 3, 2, 1'b0, "after_rst");

      do_reset();
      run_stream(DEPTH, 1, 0, 1'b0, "full_depth");

`ifdef BOOT_CHECKSUM_EN
      do_reset();
      run_stream(2, 3, 1, 1'b1, "csum_bad");
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/boot_loader.md
# boot_loader

Boot-time load sequencer for the rv32i single-core CPU. It accepts a word stream over a valid/ready handshake, writes the data image into the data BRAM and the program image into the instruction BRAM through their write ports, and holds the CPU stalled while loading. Once loading completes, it hands data BRAM write control to the CPU datapath and releases the PC.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12. Byte-address width of both BRAM write ports.
- `I_DEPTH_WORDS`, default 1024. Capacity of the instruction BRAM in words.
- `D_DEPTH_WORDS`, default 1024. Capacity of the data BRAM in words.

Ports:
- `clk`  in  1  System clock. Single clock domain.
- `rst`  in  1  Synchronous, active-high reset.
- `s_valid`  in  1  Stream word valid.
- `s_data`  in  `DATA_WIDTH`  Stream word.
- `s_ready`  out  1  Loader accepts a word when `s_valid & s_ready`.
- `i_w_addr`  out  `ADDR_WIDTH`  Instruction BRAM byte write address.
- `i_w_dat`  out  `DATA_WIDTH`  Instruction BRAM write data.
- `i_w_enb`  out  1  Instruction BRAM write enable.
- `i_w_byte_enb`  out  4  Instruction BRAM byte enables.
- `d_w_addr`  out  `ADDR_WIDTH`  Data BRAM byte write address.
- `d_w_dat`  out  `DATA_WIDTH`  Data BRAM write data.
- `d_w_enb`  out  1  Data BRAM write enable.
- `d_w_byte_enb`  out  4  Data BRAM byte enables.
- `d_bram_init_done`  out  1  Data BRAM write port muxed to the CPU datapath.
- `pc_stall`  out  1  PC stall.
- `rd_enbl`  out  1  Register file read enable.
- `i_r_enb`  out  1  Instruction BRAM read enable.
- `boot_done`  out  1  Load complete; CPU running.
- `boot_error`  out  1  Load aborted; CPU held stalled.

## Operation
- The stream format is:
  - header word: `[31:16]` = data word count ND, `[15:0]` = instruction word count NI;
  - then ND data words;
  - then NI instruction words;
  - then the checksum word, only when `BOOT_CHECKSUM_EN` is defined.
- FSM states: HDR, LOAD_D, LOAD_I, CHECK, RUN, ERR.
- HDR:
  - `s_ready`=1.
  - On accept, latch ND/NI and clear both word counters.
  - If ND>`D_DEPTH_WORDS` or NI>`I_DEPTH_WORDS`, go to ERR.
  - Otherwise go to LOAD_D if ND≠0, else LOAD_I if NI≠0, else CHECK (macro on) or RUN (macro off).
- LOAD_D:
  - `s_ready`=1.
  - Each accepted word k (0-based) is written to data address k*4 with byte enables 4'b1111.
  - After word ND-1, go to LOAD_I, or to CHECK/RUN if NI=0.
- LOAD_I:
  - Each accepted word k is written to instruction address k*4 with byte enables 4'b1111.
  - After word NI-1, go to CHECK (macro on) or RUN (macro off).
- CHECK: see Configuration.
- RUN is terminal:
  - `s_ready`=0, `pc_stall`=0, `rd_enbl`=1, `i_r_enb`=1, `boot_done`=1.
  - Stream words are ignored.
- ERR is terminal:
  - `s_ready`=0, `pc_stall`=1, `boot_error`=1.
  - Leaving ERR requires `rst`.
- Word counters are `ADDR_WIDTH`-2 bits wide. The address is `{count, 2'b00}`, so no wrap can occur because the depth check is made in HDR.

## Timing
- Reset values:
  - `s_ready`=0 in the reset cycle, then 1 (HDR) from the first cycle after reset.
  - All write addresses, data and enables = 0.
  - `d_bram_init_done`=0, `pc_stall`=1, `rd_enbl`=0, `i_r_enb`=0, `boot_done`=0, `boot_error`=0.
- All outputs are registered.
- A word accepted in cycle t produces its write strobe (`*_w_enb`=1 with address and data) in cycle t+1 for exactly one cycle.
- Throughput is one word per cycle. `s_valid` gaps insert idle cycles, with enables low.
- `d_bram_init_done` rises in the cycle after the last data write strobe and stays 1 in LOAD_I, CHECK and RUN. It is 1 in ERR only if entered from CHECK.
- `pc_stall` falls, and `rd_enbl`, `i_r_enb` and `boot_done` rise, together in the cycle after the last instruction write strobe (macro off), or the cycle after the checksum is accepted (macro on).
- `rst` mid-load: the next cycle returns to HDR with all outputs at reset values. BRAM contents are not cleared.
- `s_valid` held high with `s_ready`=0 has no effect.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - A 32-bit XOR accumulator covers the header and all payload words.
  - In CHECK, `s_ready`=1. The accepted word is compared with the accumulator: equal → RUN; unequal → ERR.
- `BOOT_CHECKSUM_EN` undefined:
  - No accumulator, no CHECK state, no trailer word.
  - The last payload word leads directly to RUN.

## Structure
- FSM state encodings (`BOOT_HDR`… `BOOT_ERR`, 3 bits) belong in `rv32i_control.vh`.
- Default BRAM depths belong in `rv32i_params.vh`, reusing `I_BRAM_DEPTH`.
- One sub-module, `boot_xor_acc`, is instantiated only under `BOOT_CHECKSUM_EN`. It has clear, enable, data in and accumulator out.

## Test plan
- Header 0x0003_0008, then 3 data words 0x2A/0x02/0x0A and 8 instruction words → `d_w_addr` 0x000/0x004/0x008, `i_w_addr` 0x000…0x01C, `boot_done`=1, `pc_stall`=0.
- Header 0x0000_0002 → no data write strobes; `d_bram_init_done` rises right after HDR; 2 instruction writes, then RUN.
- Header 0x0401_0001 (ND=1025) → ERR the cycle after the header; no write strobes; `pc_stall` stays 1.
- Random `s_valid` gaps during load → write strobes only in cycles after an accept; addresses contiguous.
- `rst` asserted after the 2nd data word, then a full stream → reload starts at address 0x000 and ends in RUN.
- `BOOT_CHECKSUM_EN`: correct XOR trailer → RUN; trailer with 1 bit flipped → ERR, `boot_error`=1, `pc_stall`=1.
